memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits directly downstream of the execute stage and consumes its EXE/MEM registers (pc, alu result, rs2, instruction, rd address).
- Issues load/store requests to the data memory over a req/ready + rvalid handshake and performs byte-lane steering and load sign/zero extension.
- Stalls the pipeline while an access is outstanding, then drives the MEM/WB registers.
- Also supplies the forward_mem value consumed by the execute stage's operand muxes.

Parameters:
- XLEN, 32, datapath width; must equal `XLEN.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_mem  in  1  EXE/MEM slot holds a real instruction
- pc_mem  in  XLEN  instruction PC
- alu_mem  in  XLEN  ALU result; effective address for loads/stores
- rs2_mem  in  XLEN  store data
- instr_mem  in  XLEN  instruction word; opcode/funct3 decoded here
- rd_addr_mem  in  `REG_ADDR_WIDTH  destination register
- forward_mem  out  XLEN  combinational copy of alu_mem, to execute
- stall_mem  out  1  upstream stages hold their registers
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address {alu_mem[XLEN-1:2],2'b00}
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data word
- valid_wb  out  1  MEM/WB slot valid
- pc_wb, alu_wb, instr_wb  out  XLEN  registered pass-through
- mem_data_wb  out  XLEN  extended load result
- rd_addr_wb  out  `REG_ADDR_WIDTH  registered pass-through
- misalign_wb  out  1  present only with MEM_MISALIGN_TRAP_EN

Behaviour:
- Reset (async, rst_n low):
  - FSM → IDLE.
  - All *_wb outputs → 0; dmem_req → 0.
- Decode: is_load = valid_mem & opcode 0000011; is_store = valid_mem & opcode 0100011; size from funct3[1:0]; unsigned from funct3[2].
- Store steering:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << a[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << {a[1],1'b0}.
  - SW: wdata = rs2, be = 4'b1111.
  - Loads: be = 4'b1111, we = 0.
- FSM states IDLE, WAIT, RESP:
  - IDLE, non-memory op: no request. MEM/WB captures inputs next edge (1-cycle latency); valid_wb = valid_mem.
  - IDLE, memory op: dmem_req = 1 combinationally.
    - dmem_ready = 1 and store: complete, no stall, MEM/WB updated next edge.
    - dmem_ready = 1 and load: → RESP, stall_mem = 1.
    - dmem_ready = 0: → WAIT, stall_mem = 1.
  - WAIT: dmem_req held with identical addr/we/be/wdata (inputs are frozen by the stall). On dmem_ready: store → IDLE and completes with stall_mem = 0 that cycle; load → RESP.
  - RESP: stall_mem = 1 until dmem_rvalid. In the rvalid cycle stall_mem = 0; MEM/WB captures the extended data, valid_wb = 1; → IDLE.
  - dmem_rvalid outside RESP is ignored.
- Stall cycles: MEM/WB loads a bubble (valid_wb = 0). An instruction is committed exactly once.
- Minimum load latency: 1 stall cycle (ready in IDLE, rvalid the next cycle).
- Load extraction uses the byte offset a[1:0] latched at request acceptance:
  - LB/LBU: byte lane a[1:0], sign- or zero-extended.
  - LH/LHU: half-word lane a[1].
  - LW: full word.
- mem_data_wb = 0 for non-load instructions.
- Reset mid-access: the FSM returns to IDLE immediately; the in-flight response is ignored.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- With it:
  - Halfword with a[0] ≠ 0 or word with a[1:0] ≠ 0 raises no dmem_req and no stall.
  - MEM/WB captures the slot with misalign_wb = 1 and mem_data_wb = 0.
- Without it:
  - No misalign_wb port.
  - Low address bits select lanes as above; a halfword at offset 3 uses lanes 3:2; word accesses ignore a[1:0].

Decomposition:
- Shared constants package: opcode constants (OPC_LOAD, OPC_STORE), funct3 size encodings, and an mem_state_t enum {IDLE, WAIT, RESP}.
- One sub-module, load_align: combinational lane select plus sign/zero extension from (rdata, offset, funct3).

Test Plan:
- ADD with alu_mem = 0x1234 → next cycle alu_wb = 0x1234, valid_wb = 1, no dmem_req, stall_mem = 0.
- SB rs2 = 0xAABBCCDD, addr 0x102, ready = 1 → dmem_be = 4'b0100, dmem_wdata = 0xDDDDDDDD, dmem_addr = 0x100, no stall.
- LB addr 0x103, ready = 1, rvalid next cycle with rdata 0x80FF0011 → stall_mem high 1 cycle, mem_data_wb = 0xFFFFFF80. The same case with LBU → 0x00000080.
- SW with ready low 3 cycles → dmem_req held stable for 4 cycles, stall_mem high 3 cycles, valid_wb = 0 during the stall, then one commit.
- LW in RESP, rst_n pulsed low → FSM IDLE, dmem_req = 0, all *_wb = 0; a later rvalid is ignored.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x201 → no dmem_req, misalign_wb = 1, valid_wb = 1.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared constants for the RV32I MEM stage: opcodes, access sizes, FSM states.
// Optional misalignment trapping is selected with MEM_MISALIGN_TRAP_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package memory_access_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    // Halfwords need 2-byte alignment, words 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface memory_access_if #(parameter int XLEN = 32);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ready;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/memory_access_load_align.sv
// Load lane selection and sign/zero extension from the returned data word.
module memory_access_load_align
    import memory_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend according to funct3[2].
    always_comb begin
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3[1:0])
            SIZE_B:  data = {{(XLEN-8){byte_s[7] & ~funct3[2]}}, byte_s};
            SIZE_H:  data = {{(XLEN-16){half_s[15] & ~funct3[2]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV32I MEM stage: data-memory handshake, store steering, load alignment, MEM/WB regs.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing them.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_mem,
    input  logic [XLEN-1:0]            pc_mem,
    input  logic [XLEN-1:0]            alu_mem,
    input  logic [XLEN-1:0]            rs2_mem,
    input  logic [XLEN-1:0]            instr_mem,
    input  logic [`REG_ADDR_WIDTH-1:0] rd_addr_mem,
    output logic [XLEN-1:0]            forward_mem,
    output logic                       stall_mem,
    memory_access_if.master            dmem,
    output logic                       valid_wb,
    output logic [XLEN-1:0]            pc_wb,
    output logic [XLEN-1:0]            alu_wb,
    output logic [XLEN-1:0]            instr_wb,
    output logic [XLEN-1:0]            mem_data_wb,
    output logic [`REG_ADDR_WIDTH-1:0] rd_addr_wb
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                       misalign_wb
`endif
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            is_load_s;
    logic            is_store_s;
    logic            misal_s;
    logic            mem_op_s;
    logic [XLEN-1:0] wdata_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] load_data_s;

    logic [1:0] state_q, state_d;
    logic [1:0] off_q, off_d;
    logic       req_s;
    logic       stall_s;
    logic       commit_s;
    logic       load_done_s;

    logic                       valid_wb_q, valid_wb_d;
    logic [XLEN-1:0]            pc_wb_q, pc_wb_d;
    logic [XLEN-1:0]            alu_wb_q, alu_wb_d;
    logic [XLEN-1:0]            instr_wb_q, instr_wb_d;
    logic [XLEN-1:0]            mem_data_wb_q, mem_data_wb_d;
    logic [`REG_ADDR_WIDTH-1:0] rd_addr_wb_q, rd_addr_wb_d;
    logic                       misalign_wb_q, misalign_wb_d;

    // Instruction decode and misalignment detection.
    always_comb begin
        opcode_s   = instr_mem[6:0];
        funct3_s   = instr_mem[14:12];
        is_load_s  = valid_mem & (opcode_s == OPC_LOAD);
        is_store_s = valid_mem & (opcode_s == OPC_STORE);
`ifdef MEM_MISALIGN_TRAP_EN
        misal_s    = (is_load_s | is_store_s) & is_misaligned(funct3_s[1:0], alu_mem[1:0]);
`else
        misal_s    = 1'b0;
`endif
        mem_op_s   = (is_load_s | is_store_s) & ~misal_s;
    end

    // Store data replication and byte-enable generation.
    always_comb begin
        case (funct3_s[1:0])
            SIZE_B: begin
                wdata_s = {4{rs2_mem[7:0]}};
                be_s    = 4'b0001 << alu_mem[1:0];
            end
            SIZE_H: begin
                wdata_s = {2{rs2_mem[15:0]}};
                be_s    = 4'b0011 << {alu_mem[1], 1'b0};
            end
            default: begin
                wdata_s = rs2_mem;
                be_s    = 4'b1111;
            end
        endcase
        if (is_store_s) begin
            be_s = be_s;
        end else begin
            be_s = 4'b1111;
        end
    end

    // Access FSM: the upstream stages stay frozen while stall_s is high.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        req_s       = 1'b0;
        stall_s     = 1'b0;
        commit_s    = 1'b0;
        load_done_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op_s) begin
                    req_s = 1'b1;
                    if (dmem.dmem_ready) begin
                        if (is_store_s) begin
                            commit_s = 1'b1;
                        end else begin
                            state_d = S_RESP;
                            stall_s = 1'b1;
                            off_d   = alu_mem[1:0];
                        end
                    end else begin
                        state_d = S_WAIT;
                        stall_s = 1'b1;
                    end
                end else begin
                    commit_s = 1'b1;
                end
            end
            S_WAIT: begin
                req_s = 1'b1;
                if (dmem.dmem_ready) begin
                    if (is_store_s) begin
                        state_d  = S_IDLE;
                        commit_s = 1'b1;
                    end else begin
                        state_d = S_RESP;
                        stall_s = 1'b1;
                        off_d   = alu_mem[1:0];
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            S_RESP: begin
                if (dmem.dmem_rvalid) begin
                    state_d     = S_IDLE;
                    commit_s    = 1'b1;
                    load_done_s = 1'b1;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    memory_access_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem.dmem_rdata),
        .offset (off_q),
        .funct3 (funct3_s),
        .data   (load_data_s)
    );

    // MEM/WB next-state: commit the slot once, otherwise insert a bubble.
    always_comb begin
        if (commit_s) begin
            valid_wb_d    = valid_mem;
            pc_wb_d       = pc_mem;
            alu_wb_d      = alu_mem;
            instr_wb_d    = instr_mem;
            rd_addr_wb_d  = rd_addr_mem;
            misalign_wb_d = misal_s;
            if (load_done_s) begin
                mem_data_wb_d = load_data_s;
            end else begin
                mem_data_wb_d = {XLEN{1'b0}};
            end
        end else begin
            valid_wb_d    = 1'b0;
            pc_wb_d       = {XLEN{1'b0}};
            alu_wb_d      = {XLEN{1'b0}};
            instr_wb_d    = {XLEN{1'b0}};
            rd_addr_wb_d  = {`REG_ADDR_WIDTH{1'b0}};
            misalign_wb_d = 1'b0;
            mem_data_wb_d = {XLEN{1'b0}};
        end
    end

    // State and MEM/WB registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            off_q         <= 2'b00;
            valid_wb_q    <= 1'b0;
            pc_wb_q       <= {XLEN{1'b0}};
            alu_wb_q      <= {XLEN{1'b0}};
            instr_wb_q    <= {XLEN{1'b0}};
            mem_data_wb_q <= {XLEN{1'b0}};
            rd_addr_wb_q  <= {`REG_ADDR_WIDTH{1'b0}};
            misalign_wb_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            valid_wb_q    <= valid_wb_d;
            pc_wb_q       <= pc_wb_d;
            alu_wb_q      <= alu_wb_d;
            instr_wb_q    <= instr_wb_d;
            mem_data_wb_q <= mem_data_wb_d;
            rd_addr_wb_q  <= rd_addr_wb_d;
            misalign_wb_q <= misalign_wb_d;
        end
    end

    assign forward_mem     = alu_mem;
    assign stall_mem       = stall_s;
    assign dmem.dmem_req   = req_s;
    assign dmem.dmem_we    = is_store_s;
    assign dmem.dmem_addr  = {alu_mem[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_s;
    assign dmem.dmem_be    = be_s;

    assign valid_wb    = valid_wb_q;
    assign pc_wb       = pc_wb_q;
    assign alu_wb      = alu_wb_q;
    assign instr_wb    = instr_wb_q;
    assign mem_data_wb = mem_data_wb_q;
    assign rd_addr_wb  = rd_addr_wb_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_wb = misalign_wb_q;
`else
    logic unused_misal_s;
    assign unused_misal_s = misalign_wb_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a transaction-level model and per-cycle compare.
module tb_memory_access;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_OP    = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_mem = 1'b0;
    logic [31:0] pc_mem = 32'h0, alu_mem = 32'h0, rs2_mem = 32'h0, instr_mem = 32'h0;
    logic [4:0]  rd_addr_mem = 5'h0;
    logic [31:0] forward_mem;
    logic        stall_mem;
    logic        valid_wb;
    logic [31:0] pc_wb, alu_wb, instr_wb, mem_data_wb;
    logic [4:0]  rd_addr_wb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_wb;
`endif

    int errors = 0;
    int checks = 0;

    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_vwb = 1'b0, exp_full = 1'b0, exp_mis = 1'b0;
    logic [31:0] exp_pc, exp_alu, exp_instr, exp_md;
    logic [4:0]  exp_rd;

    always #5 clk = ~clk;

    memory_access_if #(.XLEN(32)) dmem ();

    memory_access #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_mem   (valid_mem),
        .pc_mem      (pc_mem),
        .alu_mem     (alu_mem),
        .rs2_mem     (rs2_mem),
        .instr_mem   (instr_mem),
        .rd_addr_mem (rd_addr_mem),
        .forward_mem (forward_mem),
        .stall_mem   (stall_mem),
        .dmem        (dmem),
        .valid_wb    (valid_wb),
        .pc_wb       (pc_wb),
        .alu_wb      (alu_wb),
        .instr_wb    (instr_wb),
        .mem_data_wb (mem_data_wb),
        .rd_addr_wb  (rd_addr_wb)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_wb (misalign_wb)
`endif
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Access width in bytes; funct3 size 3 is treated as a word.
    function automatic int nbytes(input logic [2:0] f3);
        int n;
        n = 1 << f3[1:0];
        if (n > 4) n = 4;
        return n;
    endfunction

    function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return (n == 4) ? 0 : ((int'(a % 4) / n) * n);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int b, n;
        b = lane_base(f3, a);
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + n);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v, mask;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * lane_base(f3, a));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic model_misal(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
    endfunction

    // Per-cycle compare of the DUT against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("stall_mem", stall_mem, exp_stall);
            chk1("dmem_req", dmem.dmem_req, exp_req);
            chk32("forward_mem", forward_mem, alu_mem);
            if (exp_req) begin
                chk32("dmem_addr", dmem.dmem_addr, exp_addr);
                chk1("dmem_we", dmem.dmem_we, exp_we);
                chk32("dmem_be", {28'h0, dmem.dmem_be}, {28'h0, exp_be});
                if (exp_we) chk32("dmem_wdata", dmem.dmem_wdata, exp_wdata);
            end
            chk1("valid_wb", valid_wb, exp_vwb);
            if (exp_full) begin
                chk32("pc_wb", pc_wb, exp_pc);
                chk32("alu_wb", alu_wb, exp_alu);
                chk32("instr_wb", instr_wb, exp_instr);
                chk32("rd_addr_wb", {27'h0, rd_addr_wb}, {27'h0, exp_rd});
                chk32("mem_data_wb", mem_data_wb, exp_md);
`ifdef MEM_MISALIGN_TRAP_EN
                chk1("misalign_wb", misalign_wb, exp_mis);
`endif
            end
        end
    end

    // One instruction: w cycles of ready low, then for loads r extra RESP cycles before rvalid.
    task automatic run_op(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] a, input logic [31:0] rs2,
                          input logic [4:0] rd, input int w, input int r, input logic [31:0] rdata,
                          output int n_stall, output int n_req, output logic [3:0] s_be,
                          output logic [31:0] s_wdata, output logic [31:0] s_addr);
        logic ld, st, mis, mem;
        int n;
        ld = v && (opc == T_LOAD);
        st = v && (opc == T_STORE);
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (ld || st) && model_misal(f3, a);
`else
        mis = 1'b0;
`endif
        mem = (ld || st) && !mis;
        n = !mem ? 1 : (st ? w + 1 : w + r + 2);
        valid_mem   = v;
        pc_mem      = pc;
        alu_mem     = a;
        rs2_mem     = rs2;
        rd_addr_mem = rd;
        instr_mem   = {17'h0, f3, 5'h0, opc};
        dmem.dmem_rdata = rdata;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = st;
        exp_be    = st ? model_be(f3, a) : 4'hF;
        exp_wdata = model_wdata(f3, rs2);
        n_stall = 0;
        n_req   = 0;
        s_be    = 4'h0;
        s_wdata = 32'h0;
        s_addr  = 32'h0;
        for (int k = 0; k < n; k++) begin
            dmem.dmem_ready  = mem && (k == w);
            dmem.dmem_rvalid = ld && mem && (k == w + 1 + r);
            exp_req   = mem && (k <= w);
            exp_stall = (k < n - 1);
            chk_en    = 1'b1;
            @(negedge clk);
            if (stall_mem) n_stall++;
            if (dmem.dmem_req) n_req++;
            if (k == 0) begin
                s_be    = dmem.dmem_be;
                s_wdata = dmem.dmem_wdata;
                s_addr  = dmem.dmem_addr;
            end
            @(posedge clk);
            #1;
            if (k == n - 1) begin
                exp_vwb   = v;
                exp_full  = 1'b1;
                exp_pc    = pc;
                exp_alu   = a;
                exp_instr = {17'h0, f3, 5'h0, opc};
                exp_rd    = rd;
                exp_md    = (ld && mem) ? model_load(f3, a, rdata) : 32'h0;
                exp_mis   = mis;
            end else begin
                exp_vwb  = 1'b0;
                exp_full = 1'b0;
            end
        end
        dmem.dmem_ready  = 1'b0;
        dmem.dmem_rvalid = 1'b0;
    endtask

    int          ns, nr;
    logic [3:0]  sbe;
    logic [31:0] swd, sad;

    initial begin
        dmem.dmem_ready  = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = 32'h0;
        exp_pc = 32'h0; exp_alu = 32'h0; exp_instr = 32'h0; exp_md = 32'h0; exp_rd = 5'h0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_valid_wb", valid_wb, 1'b0);
        chk32("reset_alu_wb", alu_wb, 32'h0);
        chk1("reset_dmem_req", dmem.dmem_req, 1'b0);
        rst_n = 1'b1;
        exp_full = 1'b1;

        run_op(1'b1, T_OP, 3'b000, 32'h0000_1000, 32'h0000_1234, 32'h0, 5'd3, 0, 0, 32'h0, ns, nr, sbe, swd, sad);
        chk32("add_alu_wb", alu_wb, 32'h0000_1234);
        chk1("add_valid_wb", valid_wb, 1'b1);
        chk32("add_req_cycles", nr, 32'd0);
        chk32("add_stall_cycles", ns, 32'd0);

        run_op(1'b1, T_STORE, 3'b000, 32'h0000_1004, 32'h0000_0102, 32'hAABB_CCDD, 5'd0, 0, 0, 32'h0, ns, nr, sbe, swd, sad);
        chk32("sb_be", {28'h0, sbe}, 32'h0000_0004);
        chk32("sb_wdata", swd, 32'hDDDD_DDDD);
        chk32("sb_addr", sad, 32'h0000_0100);
        chk32("sb_stall_cycles", ns, 32'd0);

        run_op(1'b1, T_LOAD, 3'b000, 32'h0000_1008, 32'h0000_0103, 32'h0, 5'd5, 0, 0, 32'h80FF_0011, ns, nr, sbe, swd, sad);
        chk32("lb_stall_cycles", ns, 32'd1);
        chk32("lb_data", mem_data_wb, 32'hFFFF_FF80);

        run_op(1'b1, T_LOAD, 3'b100, 32'h0000_100C, 32'h0000_0103, 32'h0, 5'd6, 0, 0, 32'h80FF_0011, ns, nr, sbe, swd, sad);
        chk32("lbu_data", mem_data_wb, 32'h0000_0080);

        run_op(1'b1, T_STORE, 3'b010, 32'h0000_1010, 32'h0000_0404, 32'h1357_9BDF, 5'd0, 3, 0, 32'h0, ns, nr, sbe, swd, sad);
        chk32("sw_req_cycles", nr, 32'd4);
        chk32("sw_stall_cycles", ns, 32'd3);
        chk1("sw_commit", valid_wb, 1'b1);

        run_op(1'b1, T_LOAD, 3'b001, 32'h0000_1014, 32'h0000_0502, 32'h0, 5'd7, 1, 2, 32'h8001_7FFF, ns, nr, sbe, swd, sad);
        chk32("lh_data", mem_data_wb, 32'hFFFF_8001);
        chk32("lh_stall_cycles", ns, 32'd4);

        run_op(1'b1, T_LOAD, 3'b101, 32'h0000_1018, 32'h0000_0500, 32'h0, 5'd8, 0, 1, 32'h8001_7FFF, ns, nr, sbe, swd, sad);
        chk32("lhu_data", mem_data_wb, 32'h0000_7FFF);

        run_op(1'b1, T_STORE, 3'b001, 32'h0000_101C, 32'h0000_0606, 32'h1234_5678, 5'd0, 0, 0, 32'h0, ns, nr, sbe, swd, sad);
        chk32("sh_be", {28'h0, sbe}, 32'h0000_000C);
        chk32("sh_wdata", swd, 32'h5678_5678);

        run_op(1'b1, T_LOAD, 3'b010, 32'h0000_1020, 32'h0000_0700, 32'h0, 5'd9, 2, 0, 32'hCAFE_F00D, ns, nr, sbe, swd, sad);
        chk32("lw_data", mem_data_wb, 32'hCAFE_F00D);

        run_op(1'b1, T_LOAD, 3'b001, 32'h0000_1024, 32'h0000_0803, 32'h0, 5'd10, 0, 0, 32'hA5B6_C7D8, ns, nr, sbe, swd, sad);
`ifndef MEM_MISALIGN_TRAP_EN
        chk32("lh_off3_data", mem_data_wb, 32'hFFFF_A5B6);
`endif

`ifdef MEM_MISALIGN_TRAP_EN
        run_op(1'b1, T_LOAD, 3'b010, 32'h0000_1028, 32'h0000_0201, 32'h0, 5'd11, 0, 0, 32'h1111_1111, ns, nr, sbe, swd, sad);
        chk32("mis_req_cycles", nr, 32'd0);
        chk1("mis_flag", misalign_wb, 1'b1);
        chk1("mis_valid", valid_wb, 1'b1);
        chk32("mis_data", mem_data_wb, 32'h0);
`endif

        run_op(1'b0, T_OP, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, ns, nr, sbe, swd, sad);

        // Reset while a load waits in RESP; the late response must be dropped.
        chk_en = 1'b0;
        valid_mem = 1'b1;
        instr_mem = {17'h0, 3'b010, 5'h0, T_LOAD};
        alu_mem = 32'h0000_0300;
        dmem.dmem_ready = 1'b1;
        @(posedge clk);
        #1;
        dmem.dmem_ready = 1'b0;
        chk1("resp_stall", stall_mem, 1'b1);
        rst_n = 1'b0;
        valid_mem = 1'b0;
        #1;
        chk1("rst_req", dmem.dmem_req, 1'b0);
        chk1("rst_stall", stall_mem, 1'b0);
        chk1("rst_valid_wb", valid_wb, 1'b0);
        chk32("rst_pc_wb", pc_wb, 32'h0);
        chk32("rst_alu_wb", alu_wb, 32'h0);
        chk32("rst_instr_wb", instr_wb, 32'h0);
        chk32("rst_mem_data_wb", mem_data_wb, 32'h0);
        chk32("rst_rd_addr_wb", {27'h0, rd_addr_wb}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("late_rvalid_stall", stall_mem, 1'b0);
        @(posedge clk);
        #1;
        dmem.dmem_rvalid = 1'b0;
        chk1("late_rvalid_valid_wb", valid_wb, 1'b0);
        chk32("late_rvalid_data", mem_data_wb, 32'h0);

        exp_vwb = 1'b0;
        exp_full = 1'b0;
        run_op(1'b1, T_OP, 3'b000, 32'h0000_2000, 32'h0000_BEEF, 32'h0, 5'd12, 0, 0, 32'h0, ns, nr, sbe, swd, sad);
        chk32("post_rst_alu_wb", alu_wb, 32'h0000_BEEF);
        run_op(1'b0, T_OP, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, ns, nr, sbe, swd, sad);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
